// File: rtl/thermal_monitor.sv
// Die temperature monitor: slow sampling, sensor-error rejection, boxcar filter,
// min/max tracking and a hysteretic NORM/WARN/CRIT/FAULT thermal-shutdown FSM.
module thermal_monitor #(
    parameter int SAMPLE_DIV = 65536,
    parameter int AVG_LOG2   = 2,
    parameter int HYST       = 3,
    parameter int ERR_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              sclr_n,
    input  logic signed [7:0] degrees_c,
    input  logic signed [7:0] warn_thresh,
    input  logic signed [7:0] crit_thresh,
    input  logic              clear_minmax,
    input  logic              clear_latch,
    output logic signed [7:0] temp_filt,
    output logic              temp_valid,
    output logic signed [7:0] temp_min,
    output logic signed [7:0] temp_max,
    output logic [1:0]        alarm_state,
    output logic              shutdown_req,
    output logic              crit_latched
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW    = 8 + AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic signed [8:0] HYST_9 = 9'(HYST);

    // state | meaning: NORM below warn, WARN warm, CRIT shutdown, FAULT sensor lost
    typedef enum logic [1:0] {
        NORM  = 2'd0,
        WARN  = 2'd1,
        CRIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t state;

    logic [CW-1:0] count;
    logic          tick;

    assign tick = (count == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    logic signed [7:0] samp;
    logic              samp_vld;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            samp     <= '0;
            samp_vld <= 1'b0;
        end else begin
            samp_vld <= tick;
            if (tick) begin
                samp <= degrees_c;
            end
        end
    end

    logic       samp_err;
    logic [7:0] err_cnt;
    logic [7:0] err_inc;
    logic       fault_hit;
    logic       fault_exit;
    logic       accept;

    assign samp_err   = (samp == 8'sd0);
    assign err_inc    = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
    assign fault_hit  = samp_vld && samp_err && (err_inc >= 8'(ERR_LIMIT));
    assign fault_exit = samp_vld && !samp_err && (state == FAULT);
    assign accept     = samp_vld && !samp_err && (state != FAULT);

    logic signed [7:0]    window [DEPTH];
    logic signed [SW-1:0] sum;
    logic [FW-1:0]        fill;
    logic                 s1_new;

    // Leaving FAULT restarts the filter from empty so stale history is never averaged in.
    always_ff @(posedge clk) begin
        if (!sclr_n || fault_exit) begin
            for (int i = 0; i < DEPTH; i++) begin
                window[i] <= '0;
            end
            sum  <= '0;
            fill <= '0;
        end else if (accept) begin
            window[0] <= samp;
            for (int i = 1; i < DEPTH; i++) begin
                window[i] <= window[i-1];
            end
            sum <= sum + SW'(samp) - SW'(window[DEPTH-1]);
            if (fill != FW'(DEPTH)) begin
                fill <= fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            err_cnt <= '0;
            s1_new  <= 1'b0;
        end else begin
            s1_new <= accept;
            if (samp_vld) begin
                err_cnt <= samp_err ? err_inc : 8'd0;
            end
        end
    end

    logic s2_new;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            temp_filt  <= '0;
            temp_valid <= 1'b0;
            s2_new     <= 1'b0;
        end else begin
            s2_new <= s1_new;
            if (fault_exit) begin
                temp_valid <= 1'b0;
            end else if (s1_new) begin
                temp_filt  <= 8'(sum >>> AVG_LOG2);
                temp_valid <= (fill == FW'(DEPTH));
            end
        end
    end

    logic eval;

    assign eval = s2_new && temp_valid;

    always_ff @(posedge clk) begin
        if (!sclr_n || clear_minmax) begin
            temp_min <= 8'sd127;
            temp_max <= -8'sd128;
        end else if (eval) begin
            if (temp_filt < temp_min) begin
                temp_min <= temp_filt;
            end
            if (temp_filt > temp_max) begin
                temp_max <= temp_filt;
            end
        end
    end

    logic signed [8:0] filt_9;
    logic signed [8:0] warn_9;
    logic signed [8:0] crit_9;
    logic signed [8:0] warn_lo;
    logic signed [8:0] crit_lo;

    assign filt_9  = 9'(temp_filt);
    assign warn_9  = 9'(warn_thresh);
    assign crit_9  = 9'(crit_thresh);
    assign warn_lo = warn_9 - HYST_9;
    assign crit_lo = crit_9 - HYST_9;

    // A CRIT entry sets the latch after a same-cycle clear_latch, so the set wins.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state        <= NORM;
            crit_latched <= 1'b0;
        end else begin
            if (clear_latch) begin
                crit_latched <= 1'b0;
            end
            if (fault_hit) begin
                state <= FAULT;
            end else if (fault_exit) begin
                state <= NORM;
            end else if (eval) begin
                case (state)
                    NORM: begin
                        if (filt_9 >= crit_9) begin
                            state        <= CRIT;
                            crit_latched <= 1'b1;
                        end else if (filt_9 >= warn_9) begin
                            state <= WARN;
                        end
                    end
                    WARN: begin
                        if (filt_9 >= crit_9) begin
                            state        <= CRIT;
                            crit_latched <= 1'b1;
                        end else if (filt_9 < warn_lo) begin
                            state <= NORM;
                        end
                    end
                    CRIT: begin
                        if (filt_9 < warn_lo) begin
                            state <= NORM;
                        end else if (filt_9 < crit_lo) begin
                            state <= WARN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign alarm_state  = state;
    assign shutdown_req = (state == CRIT) || (state == FAULT);

endmodule

// File: tb/tb_thermal_monitor.sv
// Bench for thermal_monitor: directed scenarios plus random samples, checked every
// cycle against a tick-timeline model built from queues and plain arithmetic.
module tb_thermal_monitor;

    localparam int SAMPLE_DIV = 16;
    localparam int AVG_LOG2   = 2;
    localparam int HYST       = 3;
    localparam int ERR_LIMIT  = 8;
    localparam int DEPTH      = 4;

    logic              clk = 1'b0;
    logic              sclr_n;
    logic signed [7:0] degrees_c;
    logic signed [7:0] warn_thresh;
    logic signed [7:0] crit_thresh;
    logic              clear_minmax;
    logic              clear_latch;
    logic signed [7:0] temp_filt;
    logic              temp_valid;
    logic signed [7:0] temp_min;
    logic signed [7:0] temp_max;
    logic [1:0]        alarm_state;
    logic              shutdown_req;
    logic              crit_latched;

    thermal_monitor #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .AVG_LOG2  (AVG_LOG2),
        .HYST      (HYST),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clk         (clk),
        .sclr_n      (sclr_n),
        .degrees_c   (degrees_c),
        .warn_thresh (warn_thresh),
        .crit_thresh (crit_thresh),
        .clear_minmax(clear_minmax),
        .clear_latch (clear_latch),
        .temp_filt   (temp_filt),
        .temp_valid  (temp_valid),
        .temp_min    (temp_min),
        .temp_max    (temp_max),
        .alarm_state (alarm_state),
        .shutdown_req(shutdown_req),
        .crit_latched(crit_latched)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // Model: each tick's sample takes effect 1, 2 and 3 edges after the tick edge.
    int m_tcnt = 0, m_age = 100, tick_num = 0, m_smp = 0, m_err = 0;
    int m_state = 0, m_filt = 0, m_min = 127, m_max = -128;
    bit m_valid = 1'b0, m_latch = 1'b0, m_acc = 1'b0;
    int q[$];

    function automatic int floor_div(input int s, input int d);
        int r;
        r = s / d;
        if ((s % d) != 0 && s < 0) r = r - 1;
        return r;
    endfunction

    function automatic int next_alarm(input int st, input int t, input int w, input int c);
        case (st)
            0:       return (t >= c) ? 2 : ((t >= w) ? 1 : 0);
            1:       return (t >= c) ? 2 : ((t < w - HYST) ? 0 : 1);
            2:       return (t < w - HYST) ? 0 : ((t < c - HYST) ? 1 : 2);
            default: return st;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!sclr_n) begin
            m_tcnt = 0; m_age = 100; q.delete(); m_err = 0; m_state = 0; m_filt = 0;
            m_valid = 1'b0; m_latch = 1'b0; m_min = 127; m_max = -128; m_acc = 1'b0;
        end else begin
            int nxt;
            int s;
            if (m_age < 100) m_age++;
            if (clear_latch) m_latch = 1'b0;
            if (m_age == 3 && m_acc && m_valid) begin
                if (m_filt < m_min) m_min = m_filt;
                if (m_filt > m_max) m_max = m_filt;
                nxt = next_alarm(m_state, m_filt, int'(warn_thresh), int'(crit_thresh));
                if (nxt == 2 && m_state != 2) m_latch = 1'b1;
                m_state = nxt;
            end
            if (clear_minmax) begin
                m_min = 127;
                m_max = -128;
            end
            if (m_age == 2 && m_acc) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_filt  = floor_div(s, DEPTH);
                m_valid = (q.size() == DEPTH);
            end
            if (m_age == 1) begin
                m_acc = 1'b0;
                if (m_smp == 0) begin
                    if (m_err < 255) m_err++;
                    if (m_err >= ERR_LIMIT) m_state = 3;
                end else if (m_state == 3) begin
                    m_state = 0; q.delete(); m_valid = 1'b0; m_err = 0;
                end else begin
                    m_err = 0;
                    q.push_front(m_smp);
                    if (q.size() > DEPTH) void'(q.pop_back());
                    m_acc = 1'b1;
                end
            end
            if (m_tcnt == SAMPLE_DIV - 1) begin
                m_tcnt = 0; m_smp = int'(degrees_c); m_age = 0; tick_num++;
            end else begin
                m_tcnt++;
            end
        end
    end

    task automatic compare_all();
        vectors++;
        if (temp_filt !== 8'(m_filt) || temp_valid !== m_valid || temp_min !== 8'(m_min) ||
            temp_max !== 8'(m_max) || alarm_state !== 2'(m_state) ||
            shutdown_req !== (m_state >= 2) || crit_latched !== m_latch) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t dut/model: filt %0d/%0d valid %b/%b min %0d/%0d max %0d/%0d alarm %0d/%0d shut %b/%b latch %b/%b",
                     $time, temp_filt, m_filt, temp_valid, m_valid, temp_min, m_min, temp_max, m_max,
                     alarm_state, m_state, shutdown_req, (m_state >= 2), crit_latched, m_latch);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: dut=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic feed(input int v);
        int n0;
        int guard;
        n0 = tick_num;
        guard = 0;
        degrees_c = 8'(v);
        while (tick_num == n0 && guard < 40) begin
            step();
            guard++;
        end
        if (tick_num == n0) begin
            errors++;
            $display("FAIL tick_wait: no sample tick within %0d cycles", guard);
        end
    endtask

    task automatic ramp(input int v, input int exp_state, input string nm);
        for (int i = 0; i < 4; i++) feed(v);
        cycles(3);
        lit(nm, int'(alarm_state), exp_state);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c, v, burst;
        sclr_n = 1'b0; degrees_c = '0; warn_thresh = 8'sd85; crit_thresh = 8'sd100;
        clear_minmax = 1'b0; clear_latch = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        sclr_n = 1'b1;
        lit("rst_filt", int'(temp_filt), 0);
        lit("rst_valid", int'(temp_valid), 0);
        lit("rst_min", int'(temp_min), 127);
        lit("rst_max", int'(temp_max), -128);
        lit("rst_alarm", int'(alarm_state), 0);
        lit("rst_shutdown", int'(shutdown_req), 0);
        lit("rst_latch", int'(crit_latched), 0);

        feed(25); feed(26); feed(27);
        cycles(3);
        lit("valid_after_3", int'(temp_valid), 0);
        feed(28);
        step();
        lit("valid_tick_plus1", int'(temp_valid), 0);
        step();
        lit("valid_tick_plus2", int'(temp_valid), 1);
        lit("filt_pos_avg", int'(temp_filt), 26);
        step();
        lit("first_min", int'(temp_min), 26);

        feed(-3); feed(-4); feed(-4); feed(-4);
        cycles(2);
        lit("filt_neg_floor", int'(temp_filt), -4);
        step();

        ramp(80, 0, "hyst_80_norm");
        ramp(86, 1, "hyst_86_warn");
        ramp(101, 2, "hyst_101_crit");
        lit("latch_on_crit", int'(crit_latched), 1);
        ramp(98, 2, "hyst_98_hold");
        ramp(97, 2, "hyst_97_boundary_hold");
        ramp(96, 1, "hyst_96_warn");
        ramp(81, 0, "hyst_81_norm");
        lit("latch_sticky", int'(crit_latched), 1);
        clear_latch = 1'b1; step(); clear_latch = 1'b0;
        lit("latch_cleared", int'(crit_latched), 0);

        feed(30); feed(30); feed(30);
        cycles(3);
        clear_minmax = 1'b1; step(); clear_minmax = 1'b0;
        feed(30); feed(90); feed(-70);
        cycles(3);
        lit("minmax_filt", int'(temp_filt), 20);
        lit("minmax_min", int'(temp_min), 20);
        lit("minmax_max", int'(temp_max), 45);
        feed(50);
        cycles(2);
        clear_minmax = 1'b1; step(); clear_minmax = 1'b0;
        lit("clear_wins_min", int'(temp_min), 127);
        lit("clear_wins_max", int'(temp_max), -128);

        for (int i = 0; i < 7; i++) feed(0);
        step();
        lit("err7_no_fault", int'(alarm_state), 0);
        feed(40);
        cycles(3);
        lit("err7_then_valid", int'(alarm_state), 0);
        for (int i = 0; i < 8; i++) feed(0);
        step();
        lit("fault_entry", int'(alarm_state), 3);
        lit("fault_shutdown", int'(shutdown_req), 1);
        feed(40);
        step();
        lit("fault_exit_norm", int'(alarm_state), 0);
        lit("fault_exit_valid", int'(temp_valid), 0);
        cycles(3);

        for (int i = 0; i < 4; i++) feed(120);
        cycles(3);
        lit("crit_before_rst", int'(alarm_state), 2);
        sclr_n = 1'b0; step(); sclr_n = 1'b1;
        lit("rst_crit_alarm", int'(alarm_state), 0);
        lit("rst_crit_valid", int'(temp_valid), 0);
        lit("rst_crit_latch", int'(crit_latched), 0);
        feed(50); feed(60);
        sclr_n = 1'b0; cycles(2); sclr_n = 1'b1;
        feed(10); feed(20); feed(30); feed(40);
        cycles(2);
        lit("rst_window_filt", int'(temp_filt), 25);
        lit("rst_window_valid", int'(temp_valid), 1);

        w = 85; c = 100; burst = 0;
        for (int k = 0; k < 160; k++) begin
            if (k % 12 == 0) begin
                w = int'($urandom_range(110)) - 20;
                c = w + 1 + int'($urandom_range(35));
                if (c > 127) c = 127;
                warn_thresh = 8'(w);
                crit_thresh = 8'(c);
            end
            if (burst > 0) begin
                v = 0;
                burst--;
            end else if ($urandom_range(11) == 0) begin
                burst = int'($urandom_range(10, 4));
                v = 0;
            end else begin
                v = w - 12 + int'($urandom_range(c - w + 24));
                if (v > 127) v = 127;
                if (v < -128) v = -128;
            end
            case ($urandom_range(15))
                0: begin
                    cycles(int'($urandom_range(12)));
                    clear_minmax = 1'b1; step(); clear_minmax = 1'b0;
                end
                1: begin
                    cycles(int'($urandom_range(12)));
                    clear_latch = 1'b1; step(); clear_latch = 1'b0;
                end
                2: begin
                    if ($urandom_range(3) == 0) begin
                        sclr_n = 1'b0; step(); sclr_n = 1'b1;
                    end
                end
                default: begin
                end
            endcase
            feed(v);
        end
        cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
